// File: rtl/mpu_viol_log.sv
// MPU violation logger: FIFO of denied accesses drained through a small register window.
// Optional head-record timestamps are enabled with `define MPU_VIOL_LOG_TIMESTAMP_EN.
module mpu_viol_log #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              viol_valid,
    input  logic [31:0]       viol_pc,
    input  logic [ADDR_W-1:0] viol_addr,
    input  logic              viol_write,
    input  logic [3:0]        viol_wstrb,
    input  logic              bus_valid,
    output logic              bus_ready,
    input  logic [2:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_rdata,
    output logic              irq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = 32 + 1 + 4 + ADDR_W;

    typedef enum logic {StIdle, StAck} bus_state_e;
    bus_state_e state_q, state_d;

    logic [REC_W-1:0] rec_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, irq_q;
    logic [15:0]      drop_q;

    logic ctrl_wr, pop, flush, clr, full, empty, push_ok, drop;
    logic [REC_W-1:0] head;
    logic [31:0]      head_pc, head_ts;
    logic             head_write;
    logic [3:0]       head_wstrb;
    logic [ADDR_W-1:0] head_addr;
    logic [21:0]      head_addr22;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus_valid) state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus_ready = (state_q == StAck);
    assign irq       = irq_q;

    // CTRL bits all live in byte lane 0
    assign ctrl_wr = bus_ready && bus_wstrb[0] && (bus_addr == 3'd3);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign flush   = ctrl_wr && bus_wdata[2];
    assign clr     = ctrl_wr && bus_wdata[1];
    assign pop     = ctrl_wr && bus_wdata[0] && !empty && !flush;
    assign push_ok = viol_valid && (!full || pop) && !flush;
    assign drop    = viol_valid && full && !pop && !flush;

    always_comb begin
        count_d = count_q;
        if (flush)                count_d = '0;
        else if (push_ok && !pop) count_d = count_q + CNT_W'(1);
        else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= !empty || ovf_q;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (clr) begin
                ovf_q  <= 1'b0;
                drop_q <= '0;
            end else if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Storage is not reset; every head read is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) rec_mem[wr_ptr_q] <= {viol_pc, viol_write, viol_wstrb, viol_addr};
    end

    assign head = rec_mem[rd_ptr_q];
    assign {head_pc, head_write, head_wstrb, head_addr} = head;
    assign head_addr22 = 22'(head_addr);

`ifdef MPU_VIOL_LOG_TIMESTAMP_EN
    logic [31:0] ts_q;
    logic [31:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) ts_mem[wr_ptr_q] <= ts_q;
    end

    assign head_ts = ts_mem[rd_ptr_q];
`else
    assign head_ts = '0;
`endif

    always_comb begin
        bus_rdata = '0;
        if (bus_ready && (bus_wstrb == 4'h0)) begin
            unique case (bus_addr)
                3'd0: bus_rdata = {drop_q, 6'b0, ovf_q, full, 8'(count_q)};
                3'd1: bus_rdata = empty ? 32'h0 : head_pc;
                3'd2: bus_rdata = empty ? 32'h0
                                        : {head_write, 3'b0, head_wstrb, 2'b0, head_addr22};
                3'd4: bus_rdata = empty ? 32'h0 : head_ts;
                default: bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_viol_log.sv
// Directed self-checking bench for mpu_viol_log (DEPTH=8, ADDR_W=22).
// Timestamp checks follow MPU_VIOL_LOG_TIMESTAMP_EN when it is defined.
module tb_mpu_viol_log;
    logic        clk = 1'b0;
    logic        reset;
    logic        viol_valid;
    logic [31:0] viol_pc;
    logic [21:0] viol_addr;
    logic        viol_write;
    logic [3:0]  viol_wstrb;
    logic        bus_valid;
    logic        bus_ready;
    logic [2:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rd;
    int lat;

    mpu_viol_log #(.DEPTH(8), .ADDR_W(22)) dut (
        .clk       (clk),
        .reset     (reset),
        .viol_valid(viol_valid),
        .viol_pc   (viol_pc),
        .viol_addr (viol_addr),
        .viol_write(viol_write),
        .viol_wstrb(viol_wstrb),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Drivers: called and return at posedge+1.
    task automatic push_viol(input logic [31:0] pc, input logic [21:0] a, input logic w,
                             input logic [3:0] s);
        viol_valid = 1'b1; viol_pc = pc; viol_addr = a; viol_write = w; viol_wstrb = s;
        @(posedge clk); #1;
        viol_valid = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int l);
        bus_addr = a; bus_wstrb = 4'h0; bus_wdata = '0; bus_valid = 1'b1; l = 0;
        do begin @(posedge clk); #1; l++; end while (!bus_ready && l < 8);
        n_cmp++;
        if (!bus_ready) begin
            n_err++; $display("FAIL read_timeout addr=%0d got ready=0 want ready=1", a);
        end
        d = bus_rdata;
        bus_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] data, input logic co,
                             input logic [31:0] pc, input logic [21:0] va, input logic w,
                             input logic [3:0] s);
        int l;
        bus_addr = a; bus_wstrb = 4'hF; bus_wdata = data; bus_valid = 1'b1; l = 0;
        do begin @(posedge clk); #1; l++; end while (!bus_ready && l < 8);
        n_cmp++;
        if (!bus_ready) begin
            n_err++; $display("FAIL write_timeout addr=%0d got ready=0 want ready=1", a);
        end
        if (co) begin
            viol_valid = 1'b1; viol_pc = pc; viol_addr = va; viol_write = w; viol_wstrb = s;
        end
        bus_valid = 1'b0;
        @(posedge clk); #1;
        viol_valid = 1'b0; bus_wstrb = 4'h0;
    endtask

    task automatic ctrl(input logic [31:0] data);
        bus_write(3'd3, data, 1'b0, 32'h0, 22'h0, 1'b0, 4'h0);
    endtask

    task automatic test_reset;
        reset = 1'b1; viol_valid = 1'b0; viol_pc = '0; viol_addr = '0; viol_write = 1'b0;
        viol_wstrb = '0; bus_valid = 1'b0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (bus_ready !== 1'b0) begin n_err++;
            $display("FAIL rst_ready got %b want 0", bus_ready); end
        n_cmp++; if (bus_rdata !== 32'h0) begin n_err++;
            $display("FAIL rst_rdata got %h want 0", bus_rdata); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", irq); end
        reset = 1'b0;
        @(posedge clk); #1;
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_status got %h want 0", rd); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL read_latency got %0d want 1", lat); end
        n_cmp++; if (bus_ready !== 1'b0) begin n_err++;
            $display("FAIL ready_one_cycle got %b want 0", bus_ready); end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL empty_pc got %h want 0", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL idle_irq got %b want 0", irq); end
    endtask

    task automatic test_single;
        push_viol(32'h124, 22'h300, 1'b1, 4'hF);
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL single_irq got %b want 1", irq); end
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL single_status got %h want 1", rd); end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h124) begin n_err++;
            $display("FAIL single_pc got %h want 00000124", rd); end
        bus_read(3'd2, rd, lat);
        n_cmp++; if (rd !== 32'h8F000300) begin n_err++;
            $display("FAIL single_info got %h want 8f000300", rd); end
        bus_read(3'd3, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ctrl_read got %h want 0", rd); end
        ctrl(32'h1);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL pop_status got %h want 0", rd); end
        @(posedge clk); #1;
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL pop_irq got %b want 0", irq); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 10; i++)
            push_viol(32'h1000 + 32'(4 * i), 22'h100 + 22'(i), 1'b0, 4'(i + 1));
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h00020308) begin n_err++;
            $display("FAIL ovf_status got %h want 00020308", rd); end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h1000) begin n_err++; $display("FAIL ovf_pc got %h want 1000", rd); end
        bus_read(3'd2, rd, lat);
        n_cmp++; if (rd !== 32'h01000100) begin n_err++;
            $display("FAIL ovf_info got %h want 01000100", rd); end
        bus_read(3'd5, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL off5_read got %h want 0", rd); end
        bus_read(3'd7, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL off7_read got %h want 0", rd); end
        bus_write(3'd5, 32'hFFFF_FFFF, 1'b0, 32'h0, 22'h0, 1'b0, 4'h0);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h00020308) begin n_err++;
            $display("FAIL off5_write got %h want 00020308", rd); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq got %b want 1", irq); end
    endtask

    task automatic test_pop_push_full;
        bus_write(3'd3, 32'h1, 1'b1, 32'h2000, 22'h3FFFFF, 1'b1, 4'hA);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h00020308) begin n_err++;
            $display("FAIL pp_status got %h want 00020308", rd); end
        bus_read(3'd2, rd, lat);
        n_cmp++; if (rd !== 32'h02000101) begin n_err++;
            $display("FAIL pp_info got %h want 02000101", rd); end
        for (int i = 1; i < 8; i++) begin
            bus_read(3'd1, rd, lat);
            n_cmp++; if (rd !== 32'h1000 + 32'(4 * i)) begin n_err++;
                $display("FAIL pp_order%0d got %h want %h", i, rd, 32'h1000 + 32'(4 * i)); end
            ctrl(32'h1);
        end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h2000) begin n_err++; $display("FAIL pp_last_pc got %h want 2000", rd); end
        bus_read(3'd2, rd, lat);
        n_cmp++; if (rd !== 32'h8A3FFFFF) begin n_err++;
            $display("FAIL pp_last_info got %h want 8a3fffff", rd); end
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h00020201) begin n_err++;
            $display("FAIL pp_wrap_status got %h want 00020201", rd); end
    endtask

    task automatic test_clear_ovf;
        ctrl(32'h2);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL clr_status got %h want 1", rd); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL clr_irq_busy got %b want 1", irq); end
        ctrl(32'h1);
        ctrl(32'h1);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++;
            $display("FAIL empty_pop_status got %h want 0", rd); end
        bus_read(3'd2, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL empty_info got %h want 0", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL clr_irq got %b want 0", irq); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) push_viol(32'h3000 + 32'(i), 22'h5, 1'b0, 4'h1);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL fl_pre got %h want 3", rd); end
        bus_write(3'd3, 32'h4, 1'b1, 32'h3100, 22'h6, 1'b1, 4'h3);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL fl_status got %h want 0", rd); end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL fl_pc got %h want 0", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL fl_irq got %b want 0", irq); end
    endtask

    task automatic test_clear_vs_drop;
        for (int i = 0; i < 8; i++) push_viol(32'h4000 + 32'(4 * i), 22'(i), 1'b1, 4'hF);
        bus_write(3'd3, 32'h2, 1'b1, 32'h5000, 22'h7, 1'b0, 4'h0);
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h00000108) begin n_err++;
            $display("FAIL cd_status got %h want 00000108", rd); end
        bus_read(3'd1, rd, lat);
        n_cmp++; if (rd !== 32'h4000) begin n_err++; $display("FAIL cd_pc got %h want 4000", rd); end
        ctrl(32'h4);
    endtask

    task automatic test_timestamp;
        logic [31:0] ts0, ts1;
        push_viol(32'h6000, 22'h1, 1'b0, 4'h1);
`ifdef MPU_VIOL_LOG_TIMESTAMP_EN
        repeat (4) @(posedge clk);
        #1;
        push_viol(32'h6004, 22'h2, 1'b0, 4'h1);
        bus_read(3'd4, ts0, lat);
        ctrl(32'h1);
        bus_read(3'd4, ts1, lat);
        n_cmp++; if (ts1 - ts0 !== 32'd5) begin n_err++;
            $display("FAIL ts_delta got %0d want 5", ts1 - ts0); end
        ctrl(32'h1);
        bus_read(3'd4, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ts_empty got %h want 0", rd); end
`else
        bus_read(3'd4, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ts_off got %h want 0", rd); end
        ctrl(32'h4);
`endif
    endtask

    task automatic test_reset_mid;
        push_viol(32'h7000, 22'h9, 1'b1, 4'h1);
        bus_addr = 3'd0; bus_wstrb = 4'h0; bus_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (bus_ready !== 1'b0) begin n_err++;
            $display("FAIL mid_rst_ready got %b want 0", bus_ready); end
        bus_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        bus_read(3'd0, rd, lat);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL mid_rst_status got %h want 0", rd); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq got %b want 0", irq); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_pop_push_full();
        test_clear_ovf();
        test_flush();
        test_clear_vs_drop();
        test_timestamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mpu_viol_log.md
# mpu_viol_log

Violation logger that sits directly downstream of the memory protection unit's violation output. It captures every access the MPU denies (offending PC, target word address, read/write, byte strobes) into a small FIFO. The CPU drains the FIFO through a memory-mapped register window on the native valid/ready bus, and an interrupt line signals pending records.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..128.
- ADDR_W, 22: width of the logged word address; matches the MPU→memory address width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- viol_valid  in  1  one-cycle pulse per denied access.
- viol_pc  in  32  PC of the offending instruction.
- viol_addr  in  ADDR_W  denied word address.
- viol_write  in  1  1 = denied write, 0 = denied read/fetch.
- viol_wstrb  in  4  byte strobes of the denied access.
- bus_valid  in  1  register access request; held until bus_ready.
- bus_ready  out  1  one-cycle acknowledge.
- bus_addr  in  3  word offset into register window.
- bus_wdata  in  32  write data.
- bus_wstrb  in  4  nonzero = write, zero = read.
- bus_rdata  out  32  read data, valid while bus_ready=1.
- irq  out  1  high while FIFO non-empty or overflow flag set.

## Operation
- Record = {viol_pc, viol_write, viol_wstrb, viol_addr}; pushed on viol_valid when not full.
- Push while full (without a same-cycle pop): record dropped, overflow flag set (sticky), drop counter incremented, saturating at 0xFFFF.
- Register window (word offset):
  - 0 STATUS RO: [7:0] count, [8] full, [9] overflow, [31:16] drop count.
  - 1 HEAD_PC RO: PC of oldest record; 0 when empty.
  - 2 HEAD_INFO RO: [21:0] addr (zero-extended if ADDR_W<22), [27:24] wstrb, [31] write; 0 when empty.
  - 3 CTRL WO: bit0 pop (ignored when empty), bit1 clear overflow flag and drop count, bit2 flush. Reads return 0.
  - 4 HEAD_TS RO: see Configuration.
  - 5–7: read 0; writes ignored.
- Bus FSM: IDLE → ACK when bus_valid is sampled high; ACK → IDLE unconditionally. bus_ready=1 only in ACK, so a held bus_valid is never double-accepted.
- Register side effects commit on the clock edge ending the ACK cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate log2(DEPTH)+1-bit register.

## Timing
- Reset values: bus_ready=0, bus_rdata=0, irq=0, count=0, pointers=0, overflow=0, drop count=0, FSM=IDLE.
- Read latency: bus_ready and bus_rdata are asserted exactly 1 cycle after bus_valid is first sampled. rdata reflects state at the start of the ACK cycle.
- Push is visible in STATUS/HEAD the cycle after viol_valid.
- irq is registered and updates the cycle after count or overflow changes.
- Pop and push in the same cycle: both take effect and count is unchanged. When full, this is not an overflow.
- Flush and push in the same cycle: flush wins; the push is discarded and not counted as a drop.
- Clear-overflow and drop in the same cycle: clear wins, leaving overflow=0 and drop count=0.
- Reset asserted mid-transaction: bus_ready drops immediately (async). The master must reissue the access.

## Configuration
- MPU_VIOL_LOG_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter runs from reset and wraps at 2^32.
  - Its value is captured into each record at push.
  - Offset 4 returns the head record's timestamp, or 0 when empty.
- MPU_VIOL_LOG_TIMESTAMP_EN undefined: no counter and no timestamp storage; offset 4 reads 0.

## Test plan
- Reset, then read offset 0 → rdata=0x00000000, irq=0, bus_ready exactly 1 cycle after bus_valid.
- One violation (pc=0x00000124, addr=0x300, write=1, wstrb=0xF) → STATUS=0x00000001, HEAD_PC=0x124, HEAD_INFO=0x8F000300, irq=1 next cycle. Write CTRL=1 → STATUS=0, irq=0.
- DEPTH=8: push 10 violations → STATUS count=8, full=1, overflow=1, drop=2 (0x00020308). HEAD_PC equals the first pushed PC.
- Full FIFO, violation coincident with CTRL pop → count stays 8, overflow unchanged, HEAD_PC advances to the second record.
- CTRL flush coincident with viol_valid → STATUS=0. CTRL=2 after an overflow → overflow=0, drop=0, irq=0 if empty.
- With MPU_VIOL_LOG_TIMESTAMP_EN: violations 5 cycles apart → consecutive HEAD_TS values differ by 5. Without the macro, offset 4 reads 0.
